// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode encodings, default widths and AMBA prot bundle.
package tl_pkg;

  typedef enum logic [2:0] {
    TL_A_PUT_FULL    = 3'd0,
    TL_A_PUT_PARTIAL = 3'd1,
    TL_A_GET         = 3'd4
  } tl_a_opcode_e;

  typedef enum logic [2:0] {
    TL_D_ACCESS_ACK      = 3'd0,
    TL_D_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 32;
  localparam int unsigned TL_SRC_W  = 2;

  typedef struct packed {
    logic bufferable;
    logic modifiable;
    logic readalloc;
    logic writealloc;
    logic privileged;
    logic secure;
    logic fetch;
  } tl_prot_t;

endpackage

// File: rtl/tl_channel_buffer_if.sv
// Generic ready/valid channel carrying one beat of type T.
interface tl_channel_buffer_if #(
  parameter type T = logic
) ();
  logic valid;
  logic ready;
  T     bits;

  modport master (output valid, output bits, input  ready);
  modport slave  (input  valid, input  bits, output ready);
endinterface

// File: rtl/tl_beat_queue.sv
// Registered circular FIFO with no flow-through path; ready depends only on the fill count.
module tl_beat_queue #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic                  clk,
  input  logic                  rst,
  tl_channel_buffer_if.slave    enq,
  tl_channel_buffer_if.master   deq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t enq_ptr_q, enq_ptr_d;
  ptr_t deq_ptr_q, deq_ptr_d;
  cnt_t count_q, count_d;
  T     mem_q [DEPTH];
  logic do_enq, do_deq;

  // For DEPTH = 1 the wrap compare is always true, so pointers stay at 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign enq.ready = (count_q != cnt_t'(DEPTH));
  assign deq.valid = (count_q != '0);
  assign deq.bits  = mem_q[deq_ptr_q];

  always_comb begin
    do_enq    = enq.valid & enq.ready;
    do_deq    = deq.valid & deq.ready;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq) enq_ptr_d = ptr_inc(enq_ptr_q);
    if (do_deq) deq_ptr_d = ptr_inc(deq_ptr_q);
    if (do_enq && !do_deq)      count_d = count_q + cnt_t'(1);
    else if (!do_enq && do_deq) count_d = count_q - cnt_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[enq_ptr_q] <= enq.bits;
  end

endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink-UL A/D channel buffer: one registered FIFO per channel, fields packed into beats.
module tl_channel_buffer
  import tl_pkg::*;
#(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter int unsigned ADDR_W  = TL_ADDR_W,
  parameter int unsigned DATA_W  = TL_DATA_W,
  parameter int unsigned SRC_W   = TL_SRC_W
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [2:0]          auto_in_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic                auto_in_a_bits_user_amba_prot_bufferable,
  input  logic                auto_in_a_bits_user_amba_prot_modifiable,
  input  logic                auto_in_a_bits_user_amba_prot_readalloc,
  input  logic                auto_in_a_bits_user_amba_prot_writealloc,
  input  logic                auto_in_a_bits_user_amba_prot_privileged,
  input  logic                auto_in_a_bits_user_amba_prot_secure,
  input  logic                auto_in_a_bits_user_amba_prot_fetch,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [2:0]          auto_in_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_d_bits_source,
  output logic                auto_in_d_bits_denied,
  output logic                auto_in_d_bits_corrupt,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  input  logic                auto_out_a_ready,
  output logic                auto_out_a_valid,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [2:0]          auto_out_a_bits_size,
  output logic [SRC_W-1:0]    auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic                auto_out_a_bits_user_amba_prot_bufferable,
  output logic                auto_out_a_bits_user_amba_prot_modifiable,
  output logic                auto_out_a_bits_user_amba_prot_readalloc,
  output logic                auto_out_a_bits_user_amba_prot_writealloc,
  output logic                auto_out_a_bits_user_amba_prot_privileged,
  output logic                auto_out_a_bits_user_amba_prot_secure,
  output logic                auto_out_a_bits_user_amba_prot_fetch,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  output logic                auto_out_d_ready,
  input  logic                auto_out_d_valid,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [2:0]          auto_out_d_bits_size,
  input  logic [SRC_W-1:0]    auto_out_d_bits_source,
  input  logic                auto_out_d_bits_denied,
  input  logic                auto_out_d_bits_corrupt,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data
);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [2:0]          size;
    logic [SRC_W-1:0]    source;
    logic [ADDR_W-1:0]   address;
    tl_prot_t            prot;
    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic              denied;
    logic              corrupt;
    logic [DATA_W-1:0] data;
  } tl_d_beat_t;

  tl_channel_buffer_if #(.T(tl_a_beat_t)) a_enq ();
  tl_channel_buffer_if #(.T(tl_a_beat_t)) a_deq ();
  tl_channel_buffer_if #(.T(tl_d_beat_t)) d_enq ();
  tl_channel_buffer_if #(.T(tl_d_beat_t)) d_deq ();

  assign a_enq.valid = auto_in_a_valid;
  assign a_enq.bits  = '{
    opcode:  auto_in_a_bits_opcode,
    param:   auto_in_a_bits_param,
    size:    auto_in_a_bits_size,
    source:  auto_in_a_bits_source,
    address: auto_in_a_bits_address,
    prot:    '{bufferable: auto_in_a_bits_user_amba_prot_bufferable,
               modifiable: auto_in_a_bits_user_amba_prot_modifiable,
               readalloc:  auto_in_a_bits_user_amba_prot_readalloc,
               writealloc: auto_in_a_bits_user_amba_prot_writealloc,
               privileged: auto_in_a_bits_user_amba_prot_privileged,
               secure:     auto_in_a_bits_user_amba_prot_secure,
               fetch:      auto_in_a_bits_user_amba_prot_fetch},
    mask:    auto_in_a_bits_mask,
    data:    auto_in_a_bits_data,
    corrupt: auto_in_a_bits_corrupt
  };
  assign auto_in_a_ready = a_enq.ready;

  assign auto_out_a_valid = a_deq.valid;
  assign a_deq.ready      = auto_out_a_ready;
  assign auto_out_a_bits_opcode  = a_deq.bits.opcode;
  assign auto_out_a_bits_param   = a_deq.bits.param;
  assign auto_out_a_bits_size    = a_deq.bits.size;
  assign auto_out_a_bits_source  = a_deq.bits.source;
  assign auto_out_a_bits_address = a_deq.bits.address;
  assign auto_out_a_bits_user_amba_prot_bufferable = a_deq.bits.prot.bufferable;
  assign auto_out_a_bits_user_amba_prot_modifiable = a_deq.bits.prot.modifiable;
  assign auto_out_a_bits_user_amba_prot_readalloc  = a_deq.bits.prot.readalloc;
  assign auto_out_a_bits_user_amba_prot_writealloc = a_deq.bits.prot.writealloc;
  assign auto_out_a_bits_user_amba_prot_privileged = a_deq.bits.prot.privileged;
  assign auto_out_a_bits_user_amba_prot_secure     = a_deq.bits.prot.secure;
  assign auto_out_a_bits_user_amba_prot_fetch      = a_deq.bits.prot.fetch;
  assign auto_out_a_bits_mask    = a_deq.bits.mask;
  assign auto_out_a_bits_data    = a_deq.bits.data;
  assign auto_out_a_bits_corrupt = a_deq.bits.corrupt;

  // D flows from the downstream (auto_out) side back to the upstream (auto_in) side.
  assign d_enq.valid = auto_out_d_valid;
  assign d_enq.bits  = '{
    opcode:  auto_out_d_bits_opcode,
    size:    auto_out_d_bits_size,
    source:  auto_out_d_bits_source,
    denied:  auto_out_d_bits_denied,
    corrupt: auto_out_d_bits_corrupt,
    data:    auto_out_d_bits_data
  };
  assign auto_out_d_ready = d_enq.ready;

  assign auto_in_d_valid        = d_deq.valid;
  assign d_deq.ready            = auto_in_d_ready;
  assign auto_in_d_bits_opcode  = d_deq.bits.opcode;
  assign auto_in_d_bits_size    = d_deq.bits.size;
  assign auto_in_d_bits_source  = d_deq.bits.source;
  assign auto_in_d_bits_denied  = d_deq.bits.denied;
  assign auto_in_d_bits_corrupt = d_deq.bits.corrupt;
  assign auto_in_d_bits_data    = d_deq.bits.data;

  tl_beat_queue #(.DEPTH(A_DEPTH), .T(tl_a_beat_t)) u_a_queue (
    .clk (clock),
    .rst (reset),
    .enq (a_enq),
    .deq (a_deq)
  );

  tl_beat_queue #(.DEPTH(D_DEPTH), .T(tl_d_beat_t)) u_d_queue (
    .clk (clock),
    .rst (reset),
    .enq (d_enq),
    .deq (d_deq)
  );

endmodule

// File: tb/tb_tl_channel_buffer.sv
// Directed self-checking bench for tl_channel_buffer (default build plus an A_DEPTH = 1 build).
module tb_tl_channel_buffer;
  import tl_pkg::*;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    tl_prot_t    prot;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } d_beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tl_channel_buffer_if #(.T(a_beat_t)) a_up  ();
  tl_channel_buffer_if #(.T(a_beat_t)) a_dn  ();
  tl_channel_buffer_if #(.T(d_beat_t)) d_dn  ();
  tl_channel_buffer_if #(.T(d_beat_t)) d_up  ();
  tl_channel_buffer_if #(.T(a_beat_t)) a1_up ();
  tl_channel_buffer_if #(.T(a_beat_t)) a1_dn ();
  tl_channel_buffer_if #(.T(d_beat_t)) d1_dn ();
  tl_channel_buffer_if #(.T(d_beat_t)) d1_up ();

  tl_channel_buffer dut (
    .clock(clk), .reset(rst),
    .auto_in_a_ready(a_up.ready), .auto_in_a_valid(a_up.valid),
    .auto_in_a_bits_opcode(a_up.bits.opcode), .auto_in_a_bits_param(a_up.bits.param),
    .auto_in_a_bits_size(a_up.bits.size), .auto_in_a_bits_source(a_up.bits.source),
    .auto_in_a_bits_address(a_up.bits.address),
    .auto_in_a_bits_user_amba_prot_bufferable(a_up.bits.prot.bufferable),
    .auto_in_a_bits_user_amba_prot_modifiable(a_up.bits.prot.modifiable),
    .auto_in_a_bits_user_amba_prot_readalloc(a_up.bits.prot.readalloc),
    .auto_in_a_bits_user_amba_prot_writealloc(a_up.bits.prot.writealloc),
    .auto_in_a_bits_user_amba_prot_privileged(a_up.bits.prot.privileged),
    .auto_in_a_bits_user_amba_prot_secure(a_up.bits.prot.secure),
    .auto_in_a_bits_user_amba_prot_fetch(a_up.bits.prot.fetch),
    .auto_in_a_bits_mask(a_up.bits.mask), .auto_in_a_bits_data(a_up.bits.data),
    .auto_in_a_bits_corrupt(a_up.bits.corrupt),
    .auto_in_d_ready(d_up.ready), .auto_in_d_valid(d_up.valid),
    .auto_in_d_bits_opcode(d_up.bits.opcode), .auto_in_d_bits_size(d_up.bits.size),
    .auto_in_d_bits_source(d_up.bits.source), .auto_in_d_bits_denied(d_up.bits.denied),
    .auto_in_d_bits_corrupt(d_up.bits.corrupt), .auto_in_d_bits_data(d_up.bits.data),
    .auto_out_a_ready(a_dn.ready), .auto_out_a_valid(a_dn.valid),
    .auto_out_a_bits_opcode(a_dn.bits.opcode), .auto_out_a_bits_param(a_dn.bits.param),
    .auto_out_a_bits_size(a_dn.bits.size), .auto_out_a_bits_source(a_dn.bits.source),
    .auto_out_a_bits_address(a_dn.bits.address),
    .auto_out_a_bits_user_amba_prot_bufferable(a_dn.bits.prot.bufferable),
    .auto_out_a_bits_user_amba_prot_modifiable(a_dn.bits.prot.modifiable),
    .auto_out_a_bits_user_amba_prot_readalloc(a_dn.bits.prot.readalloc),
    .auto_out_a_bits_user_amba_prot_writealloc(a_dn.bits.prot.writealloc),
    .auto_out_a_bits_user_amba_prot_privileged(a_dn.bits.prot.privileged),
    .auto_out_a_bits_user_amba_prot_secure(a_dn.bits.prot.secure),
    .auto_out_a_bits_user_amba_prot_fetch(a_dn.bits.prot.fetch),
    .auto_out_a_bits_mask(a_dn.bits.mask), .auto_out_a_bits_data(a_dn.bits.data),
    .auto_out_a_bits_corrupt(a_dn.bits.corrupt),
    .auto_out_d_ready(d_dn.ready), .auto_out_d_valid(d_dn.valid),
    .auto_out_d_bits_opcode(d_dn.bits.opcode), .auto_out_d_bits_size(d_dn.bits.size),
    .auto_out_d_bits_source(d_dn.bits.source), .auto_out_d_bits_denied(d_dn.bits.denied),
    .auto_out_d_bits_corrupt(d_dn.bits.corrupt), .auto_out_d_bits_data(d_dn.bits.data)
  );

  tl_channel_buffer #(.A_DEPTH(1)) dut1 (
    .clock(clk), .reset(rst),
    .auto_in_a_ready(a1_up.ready), .auto_in_a_valid(a1_up.valid),
    .auto_in_a_bits_opcode(a1_up.bits.opcode), .auto_in_a_bits_param(a1_up.bits.param),
    .auto_in_a_bits_size(a1_up.bits.size), .auto_in_a_bits_source(a1_up.bits.source),
    .auto_in_a_bits_address(a1_up.bits.address),
    .auto_in_a_bits_user_amba_prot_bufferable(a1_up.bits.prot.bufferable),
    .auto_in_a_bits_user_amba_prot_modifiable(a1_up.bits.prot.modifiable),
    .auto_in_a_bits_user_amba_prot_readalloc(a1_up.bits.prot.readalloc),
    .auto_in_a_bits_user_amba_prot_writealloc(a1_up.bits.prot.writealloc),
    .auto_in_a_bits_user_amba_prot_privileged(a1_up.bits.prot.privileged),
    .auto_in_a_bits_user_amba_prot_secure(a1_up.bits.prot.secure),
    .auto_in_a_bits_user_amba_prot_fetch(a1_up.bits.prot.fetch),
    .auto_in_a_bits_mask(a1_up.bits.mask), .auto_in_a_bits_data(a1_up.bits.data),
    .auto_in_a_bits_corrupt(a1_up.bits.corrupt),
    .auto_in_d_ready(d1_up.ready), .auto_in_d_valid(d1_up.valid),
    .auto_in_d_bits_opcode(d1_up.bits.opcode), .auto_in_d_bits_size(d1_up.bits.size),
    .auto_in_d_bits_source(d1_up.bits.source), .auto_in_d_bits_denied(d1_up.bits.denied),
    .auto_in_d_bits_corrupt(d1_up.bits.corrupt), .auto_in_d_bits_data(d1_up.bits.data),
    .auto_out_a_ready(a1_dn.ready), .auto_out_a_valid(a1_dn.valid),
    .auto_out_a_bits_opcode(a1_dn.bits.opcode), .auto_out_a_bits_param(a1_dn.bits.param),
    .auto_out_a_bits_size(a1_dn.bits.size), .auto_out_a_bits_source(a1_dn.bits.source),
    .auto_out_a_bits_address(a1_dn.bits.address),
    .auto_out_a_bits_user_amba_prot_bufferable(a1_dn.bits.prot.bufferable),
    .auto_out_a_bits_user_amba_prot_modifiable(a1_dn.bits.prot.modifiable),
    .auto_out_a_bits_user_amba_prot_readalloc(a1_dn.bits.prot.readalloc),
    .auto_out_a_bits_user_amba_prot_writealloc(a1_dn.bits.prot.writealloc),
    .auto_out_a_bits_user_amba_prot_privileged(a1_dn.bits.prot.privileged),
    .auto_out_a_bits_user_amba_prot_secure(a1_dn.bits.prot.secure),
    .auto_out_a_bits_user_amba_prot_fetch(a1_dn.bits.prot.fetch),
    .auto_out_a_bits_mask(a1_dn.bits.mask), .auto_out_a_bits_data(a1_dn.bits.data),
    .auto_out_a_bits_corrupt(a1_dn.bits.corrupt),
    .auto_out_d_ready(d1_dn.ready), .auto_out_d_valid(d1_dn.valid),
    .auto_out_d_bits_opcode(d1_dn.bits.opcode), .auto_out_d_bits_size(d1_dn.bits.size),
    .auto_out_d_bits_source(d1_dn.bits.source), .auto_out_d_bits_denied(d1_dn.bits.denied),
    .auto_out_d_bits_corrupt(d1_dn.bits.corrupt), .auto_out_d_bits_data(d1_dn.bits.data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic a_beat_t mk_a(input logic [2:0] op, input logic [2:0] prm,
                                   input logic [2:0] sz, input logic [1:0] src,
                                   input logic [31:0] addr, input logic [3:0] msk,
                                   input logic [31:0] dat, input logic [6:0] prot);
    a_beat_t b;
    b.opcode  = op;
    b.param   = prm;
    b.size    = sz;
    b.source  = src;
    b.address = addr;
    b.prot    = tl_prot_t'(prot);
    b.mask    = msk;
    b.data    = dat;
    b.corrupt = 1'b0;
    return b;
  endfunction

  function automatic d_beat_t mk_d(input int unsigned i);
    d_beat_t b;
    b.opcode  = TL_D_ACCESS_ACK_DATA;
    b.size    = 3'd2;
    b.source  = 2'(i % 4);
    b.denied  = i[0];
    b.corrupt = 1'b0;
    b.data    = i;
    return b;
  endfunction

  a_beat_t ga;
  a_beat_t pb [3];
  a_beat_t qa;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_up.valid = 1'b0;  a_up.bits = '0;  a_dn.ready = 1'b0;
    d_dn.valid = 1'b0;  d_dn.bits = '0;  d_up.ready = 1'b0;
    a1_up.valid = 1'b0; a1_up.bits = '0; a1_dn.ready = 1'b1;
    d1_dn.valid = 1'b0; d1_dn.bits = '0; d1_up.ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++)
      pb[i] = mk_a(TL_A_PUT_FULL, 3'd0, 3'd2, 2'(i), 32'h100 + 32'(4 * i), 4'hF,
                   32'h11 * (i + 1), 7'h00);

    // 1: reset state and idle after release
    #2;
    chk("rst_a_ready", a_up.ready, 1);
    chk("rst_d_ready", d_dn.ready, 1);
    chk("rst_a_valid", a_dn.valid, 0);
    chk("rst_d_valid", d_up.valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int unsigned c = 0; c < 10; c++) begin
      tick();
      chk("idle_a_ready", a_up.ready, 1);
      chk("idle_d_ready", d_dn.ready, 1);
      chk("idle_a_valid", a_dn.valid, 0);
      chk("idle_d_valid", d_up.valid, 0);
    end

    // 2: single Get, one-cycle latency, no flow-through
    ga = mk_a(TL_A_GET, 3'd0, 3'd2, 2'd1, 32'h8000_0010, 4'hF, 32'h0, 7'b1010101);
    a_up.bits = ga; a_up.valid = 1'b1; a_dn.ready = 1'b1;
    #1;
    chk("get_no_flow", a_dn.valid, 0);
    tick();
    chk("get_valid", a_dn.valid, 1);
    chk("get_beat", 128'(a_dn.bits), 128'(ga));
    a_up.valid = 1'b0;
    tick();
    chk("get_drained", a_dn.valid, 0);

    // 3: backpressure fills the FIFO, head holds, then drains in order
    a_dn.ready = 1'b0;
    a_up.bits = pb[0]; a_up.valid = 1'b1;
    chk("bp_ready0", a_up.ready, 1);
    tick();
    chk("bp_ready1", a_up.ready, 1);
    chk("bp_head0", 128'(a_dn.bits), 128'(pb[0]));
    a_up.bits = pb[1];
    tick();
    chk("bp_full", a_up.ready, 0);
    chk("bp_head1", 128'(a_dn.bits), 128'(pb[0]));
    a_up.bits = pb[2];
    tick();
    chk("bp_still_full", a_up.ready, 0);
    chk("bp_hold_valid", a_dn.valid, 1);
    chk("bp_hold_head", 128'(a_dn.bits), 128'(pb[0]));
    a_dn.ready = 1'b1;
    tick();
    chk("bp_drain_b1", 128'(a_dn.bits), 128'(pb[1]));
    chk("bp_ready_after", a_up.ready, 1);
    tick();
    chk("bp_drain_b2", 128'(a_dn.bits), 128'(pb[2]));
    chk("bp_drain_b2v", a_dn.valid, 1);
    a_up.valid = 1'b0;
    tick();
    chk("bp_empty", a_dn.valid, 0);

    // 4: 100 back-to-back D beats at full rate
    d_up.ready = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      d_dn.bits = mk_d(i); d_dn.valid = 1'b1;
      chk("d_stream_ready", d_dn.ready, 1);
      tick();
      chk("d_stream_valid", d_up.valid, 1);
      chk("d_stream_beat", 128'(d_up.bits), 128'(mk_d(i)));
    end
    d_dn.valid = 1'b0;
    tick();
    chk("d_stream_empty", d_up.valid, 0);

    // 5: reset while A holds 2 beats and D holds 1
    a_dn.ready = 1'b0; d_up.ready = 1'b0;
    a_up.bits = pb[0]; a_up.valid = 1'b1;
    d_dn.bits = mk_d(7); d_dn.valid = 1'b1;
    tick();
    a_up.bits = pb[1]; d_dn.valid = 1'b0;
    tick();
    a_up.valid = 1'b0;
    chk("mid_a_valid", a_dn.valid, 1);
    chk("mid_d_valid", d_up.valid, 1);
    chk("mid_a_full", a_up.ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_a_valid", a_dn.valid, 0);
    chk("async_d_valid", d_up.valid, 0);
    chk("async_a_ready", a_up.ready, 1);
    tick();
    rst = 1'b0;
    a_dn.ready = 1'b1; d_up.ready = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_a_valid", a_dn.valid, 0);
      chk("post_rst_d_valid", d_up.valid, 0);
    end

    // 6: A_DEPTH = 1 build, continuous offer -> one beat every two cycles
    a1_up.bits = mk_a(TL_A_PUT_PARTIAL, 3'd0, 3'd0, 2'd3, 32'h200, 4'h1, 32'h100, 7'h7F);
    a1_up.valid = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      qa = mk_a(TL_A_PUT_PARTIAL, 3'd0, 3'd0, 2'd3, 32'h200, 4'h1, 32'h100 + k, 7'h7F);
      chk("d1_ready_hi", a1_up.ready, 1);
      chk("d1_valid_lo", a1_dn.valid, 0);
      tick();
      chk("d1_valid_hi", a1_dn.valid, 1);
      chk("d1_beat", 128'(a1_dn.bits), 128'(qa));
      chk("d1_ready_lo", a1_up.ready, 0);
      a1_up.bits = mk_a(TL_A_PUT_PARTIAL, 3'd0, 3'd0, 2'd3, 32'h200, 4'h1,
                        32'h100 + k + 1, 7'h7F);
      tick();
    end
    a1_up.valid = 1'b0;
    tick();
    chk("d1_empty", a1_dn.valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
